// File: rtl/serial_mod_arbiter.sv
// serial_mod_arbiter: two requesters share one bit-serial modulo-DIVISOR engine.
// Words are accepted round-robin over valid/ready. Each word is shifted MSB-first
// through the residue update. The remainder, the divisible flag and the requester
// id are then offered on a result valid/ready handshake.
module serial_mod_arbiter #(
    parameter  int W       = 16,
    parameter  int DIVISOR = 5,
    localparam int RW      = $clog2(DIVISOR)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [W-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [W-1:0]  req1_data,
    output logic          req1_ready,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_id,
    output logic [RW-1:0] res_rem,
    output logic          res_div,
    output logic          busy
);

    localparam int          CW      = $clog2(W);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
    localparam logic [RW:0] DIV_T   = (RW + 1)'(DIVISOR);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state_q,     state_d;
    logic [RW-1:0]   residue_q,   residue_d;
    logic [CW-1:0]   count_q,     count_d;
    logic [W-1:0]    shift_q,     shift_d;
    logic            resId_q,     resId_d;
    logic            lastGrant_q, lastGrant_d;

    logic            grantSel;
    logic            anyValid;
    logic [RW:0]     trial;
    logic [RW:0]     residueNext;

    // Round-robin pick: a lone valid wins, a tie goes to whoever was not served last.
    always_comb begin
        anyValid = req0_valid | req1_valid;
        grantSel = 1'b0;
        if (req0_valid && !req1_valid) begin
            grantSel = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grantSel = 1'b1;
        end else if (req0_valid && req1_valid) begin
            grantSel = ~lastGrant_q;
        end
    end

    // One residue step: t = 2*residue + msb, reduced by one conditional subtract.
    always_comb begin
        trial       = {residue_q, shift_q[W-1]};
        residueNext = (trial >= DIV_T) ? (trial - DIV_T) : trial;
    end

    // Next-state and output decode. The readies are gated by rst_n so that every output is 0 while reset is held.
    always_comb begin
        state_d     = state_q;
        residue_d   = residue_q;
        count_d     = count_q;
        shift_d     = shift_q;
        resId_d     = resId_q;
        lastGrant_d = lastGrant_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        res_valid   = 1'b0;
        res_rem     = '0;
        res_div     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (anyValid && rst_n) begin
                    req0_ready  = ~grantSel;
                    req1_ready  = grantSel;
                    shift_d     = grantSel ? req1_data : req0_data;
                    residue_d   = '0;
                    count_d     = '0;
                    resId_d     = grantSel;
                    lastGrant_d = grantSel;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                residue_d = residueNext[RW-1:0];
                shift_d   = {shift_q[W-2:0], 1'b0};
                count_d   = count_q + CW'(1);
                if (count_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                res_rem   = residue_q;
                res_div   = (residue_q == '0);
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset discards any in-flight word and gives requester 0 the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            residue_q   <= '0;
            count_q     <= '0;
            shift_q     <= '0;
            resId_q     <= 1'b0;
            lastGrant_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            residue_q   <= residue_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            resId_q     <= resId_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    assign res_id = resId_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_serial_mod_arbiter.sv
// Scoreboard bench for serial_mod_arbiter.
// Expected results are queued as words are driven. They are checked when the result handshake fires.
module tb_serial_mod_arbiter;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0]  req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready;
    logic          res_valid, res_id, res_div, busy;
    logic          res_ready = 1'b1;
    logic [2:0]    res_rem;

    logic          bReq0Valid = 1'b0;
    logic [W-1:0]  bReq0Data = '0;
    logic          bReq0Ready, bReq1Ready;
    logic          bResValid, bResId, bResDiv, bBusy;
    logic [1:0]    bResRem;

    typedef struct {
        logic       id;
        logic [2:0] rem;
        logic       div;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acceptCyc = 0;
    bit   acceptPending = 1'b0;
    bit   prevValid = 1'b0;
    int   resultsSeen = 0;

    serial_mod_arbiter #(.W(W), .DIVISOR(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_rem(res_rem), .res_div(res_div), .busy(busy)
    );

    serial_mod_arbiter #(.W(W), .DIVISOR(3)) dutB (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(bReq0Valid), .req0_data(bReq0Data), .req0_ready(bReq0Ready),
        .req1_valid(1'b0), .req1_data('0), .req1_ready(bReq1Ready),
        .res_valid(bResValid), .res_ready(1'b1), .res_id(bResId),
        .res_rem(bResRem), .res_div(bResDiv), .busy(bBusy)
    );

    always #5 clk = ~clk;

    // Count rising edges so that result latency can be measured.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pushExp(input logic id, input logic [W-1:0] d);
        exp_t e;
        e.id  = id;
        e.rem = 3'(d % 5);
        e.div = ((d % 5) == 0);
        sbQ.push_back(e);
    endtask

    // Monitor: measure the latency from accept to result, and pop the scoreboard on each result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            acceptPending = 1'b0;
            prevValid     = 1'b0;
        end else begin
            if (res_valid && !prevValid && acceptPending) begin
                checkOutput("latency", 32'(cyc - acceptCyc), W);
                acceptPending = 1'b0;
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                acceptCyc     = cyc + 1;
                acceptPending = 1'b1;
            end
            if (res_valid && res_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("res_id", res_id, e.id);
                    checkOutput("res_rem", res_rem, e.rem);
                    checkOutput("res_div", res_div, e.div);
                end
                resultsSeen++;
            end
            prevValid = res_valid;
        end
    end

    // Offer one word on requester idx, hold it until it is accepted, and confirm that ready drops in SHIFT.
    task automatic applyStimulus(input int idx, input logic [W-1:0] d);
        bit got;
        got = 1'b0;
        pushExp(idx[0], d);
        if (idx == 0) begin req0_valid = 1'b1; req0_data = d; end
        else          begin req1_valid = 1'b1; req1_data = d; end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((idx == 0) ? req0_ready : req1_ready) begin got = 1'b1; break; end
        end
        if (!got) checkOutput("accept_timeout", 0, 1);
        @(negedge clk);
        checkOutput("ready_in_shift", (idx == 0) ? req0_ready : req1_ready, 0);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (!busy) begin done = 1'b1; break; end
        end
        if (!done) checkOutput("idle_timeout", 0, 1);
        checkOutput("idle_res_valid", res_valid, 0);
        checkOutput("idle_res_rem", res_rem, 0);
    endtask

    task automatic pulseReset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] singles [4];
        logic [W-1:0] bData [3];
        int           target;
        bit           ok;

        singles[0] = 16'd27;
        singles[1] = 16'd0;
        singles[2] = 16'hFFFF;
        singles[3] = 16'hFFFE;
        bData[0]   = 16'd21;
        bData[1]   = 16'd22;
        bData[2]   = 16'd65534;

        // While reset is held, all outputs must be 0 even though a valid is asserted.
        req0_valid = 1'b1;
        req0_data  = 16'd5;
        repeat (2) @(negedge clk);
        checkOutput("rst_req0_ready", req0_ready, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_res_id", res_id, 0);
        checkOutput("rst_res_rem", res_rem, 0);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // First word: 25 mod 5 = 0.
        @(posedge clk); #1;
        applyStimulus(0, 16'd25);
        waitIdle();

        // Single requests, alternating between the two requester ports.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            applyStimulus(i % 2, singles[i]);
            waitIdle();
        end

        // Both valids are held from reset, so the grants alternate 0,1,0,1.
        req0_valid = 1'b1; req0_data = 16'd1234;
        req1_valid = 1'b1; req1_data = 16'd777;
        pulseReset();
        pushExp(1'b0, 16'd1234);
        pushExp(1'b1, 16'd777);
        pushExp(1'b0, 16'd1234);
        pushExp(1'b1, 16'd777);
        target = resultsSeen + 4;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (resultsSeen >= target) begin ok = 1'b1; break; end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!ok) checkOutput("alternate_timeout", 0, 1);
        waitIdle();
        checkOutput("alternate_queue_empty", sbQ.size(), 0);

        // Back-pressure: the result must hold steady, and a waiting requester must get no ready.
        @(posedge clk); #1;
        res_ready = 1'b0;
        applyStimulus(0, 16'd1003);
        req1_valid = 1'b1;
        req1_data  = 16'd43;
        pushExp(1'b1, 16'd43);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1'b1; break; end
        end
        if (!ok) checkOutput("stall_result_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_res_valid", res_valid, 1);
            checkOutput("stall_res_id", res_id, 0);
            checkOutput("stall_res_rem", res_rem, 3);
            checkOutput("stall_req1_ready", req1_ready, 0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("handshake_cycle_req1_ready", req1_ready, 0);
        @(negedge clk);
        checkOutput("accept_next_cycle", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        waitIdle();

        // Reset during SHIFT bit 7: the word is dropped and requester 0 wins the next grant.
        @(posedge clk); #1;
        req1_valid = 1'b1;
        req1_data  = 16'd99;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req1_ready) begin ok = 1'b1; break; end
        end
        if (!ok) checkOutput("reset_test_accept", 0, 1);
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_data = 16'd12;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_res_valid", res_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_req0_ready", req0_ready, 0);
        checkOutput("midrst_req1_ready", req1_ready, 0);
        checkOutput("midrst_res_rem", res_rem, 0);
        checkOutput("midrst_res_id", res_id, 0);
        checkOutput("midrst_res_div", res_div, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pushExp(1'b0, 16'd12);
        @(negedge clk);
        checkOutput("post_rst_req0_ready", req0_ready, 1);
        checkOutput("post_rst_req1_ready", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waitIdle();
        checkOutput("final_queue_empty", sbQ.size(), 0);

        // DIVISOR = 3 instance.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bReq0Valid = 1'b1;
            bReq0Data  = bData[i];
            ok = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bReq0Ready) begin ok = 1'b1; break; end
            end
            if (!ok) checkOutput("b_accept_timeout", 0, 1);
            @(posedge clk); #1;
            bReq0Valid = 1'b0;
            ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (bResValid) begin ok = 1'b1; break; end
            end
            if (!ok) checkOutput("b_result_timeout", 0, 1);
            checkOutput("b_res_rem", bResRem, 32'(bData[i] % 3));
            checkOutput("b_res_div", bResDiv, ((bData[i] % 3) == 0));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
